ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Host-side driver for the configuration-chain (ccff) protocol. Accepts bitstream words over a valid/ready stream and serialises them onto ccff_head, with a shift enable that qualifies each prog_clk edge at the chain.
- Monitors ccff_tail during the load and counts the ones shifted out of the chain.
- Sits at the fabric top and feeds the head of the chain of tile config memories.

Parameters:
- WORD_W, 8: width of a bitstream input word.
- LEN_W, 16: width of the bit-length field and of the internal bit counters.

Ports:
- prog_clk  input  1  programming clock; the only clock.
- pReset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- cfg_len  input  LEN_W  number of bits to shift; sampled with start.
- abort  input  1  cancels the load in progress.
- s_data  input  WORD_W  bitstream word; shifted out LSB first.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts s_data on this cycle.
- ccff_head  output  1  serial config bit to the chain head.
- ccff_en  output  1  chain shifts on the prog_clk edge where this is 1.
- ccff_tail  input  1  serial bit from the chain tail.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when a load completes.
- tail_ones  output  LEN_W  count of 1s sampled from ccff_tail during shifts.

Behaviour:
- Reset (pReset=0, asynchronous):
  - state=IDLE.
  - s_ready, ccff_head, ccff_en, busy, done = 0; tail_ones = 0.
  - Internal shift register and counters cleared.
- States: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE:
  - start=1 with cfg_len!=0: latch len, clear bit_cnt and tail_ones, go to WAIT_WORD; busy=1 from the next cycle.
  - start=1 with cfg_len=0: go to DONE; no word is consumed.
- WAIT_WORD:
  - s_ready=1 (combinational, from state).
  - On s_valid&s_ready: load the shift register with s_data, set word_bit=0, go to SHIFT.
  - ccff_en=0 while waiting.
- SHIFT, every cycle:
  - Registered update: ccff_head<=sreg[0], ccff_en<=1, sreg>>=1, word_bit++, bit_cnt++.
  - The first bit is visible on ccff_head/ccff_en one cycle after the handshake cycle.
- Last bit of a word (word_bit=WORD_W-1) with bit_cnt+1<len:
  - s_ready=1 in that same cycle.
  - Handshake accepted: load the next word, stay in SHIFT, no bubble.
  - Not accepted: go to WAIT_WORD; ccff_en drops to 0 until a word arrives. No bit is lost or duplicated.
- Last bit of the load (bit_cnt+1=len): go to DONE.
  - Remaining high bits of a partial final word are discarded.
  - s_ready is 0 on that cycle.
- DONE:
  - done=1 for exactly one cycle.
  - ccff_en=0 from this cycle onward.
  - busy=0 on the same cycle; next state is IDLE.
- Tail monitor:
  - On every edge where ccff_en=1, ccff_tail is sampled (the value shifted out at that edge).
  - If the sample is 1, tail_ones increments, saturating at 2^LEN_W-1.
  - tail_ones holds its value after done until the next accepted start.
- abort:
  - In any non-IDLE state, abort=1 forces IDLE on the next edge.
  - ccff_en=0, busy=0 and s_ready=0 from that edge onward; done is not asserted.
  - tail_ones is frozen.
  - abort has priority over a handshake in the same cycle; that word is not consumed.
- start while busy: ignored.
- Exactly ceil(len/WORD_W) words are consumed per load.
- Over-range bit_cnt is impossible; counters are LEN_W wide and len ≤ 2^LEN_W-1.

Test Plan:
- Reset, then cfg_len=12 with words 0xA5, 0x03 and s_valid held high. Required:
  - ccff_head sequence 1,0,1,0,0,1,0,1,1,1,0,0 on 12 consecutive ccff_en=1 cycles, no bubble.
  - Exactly 2 handshakes; done pulses once on the cycle after the last bit; busy falls with it.
- Same load with s_valid withheld 3 cycles before the second word. Required:
  - ccff_en=0 for at least 3 cycles, then the same 12-bit sequence.
  - Total ccff_en-high cycles = 12.
- cfg_len=0 with start. Required:
  - done pulses one cycle later.
  - s_ready never asserts; ccff_en stays 0.
- cfg_len=20, abort asserted after the 5th shift. Required:
  - ccff_en=0 and busy=0 from the next cycle; no done pulse.
  - A subsequent start with cfg_len=8 loads cleanly.
- cfg_len=10 with ccff_tail driven as 1,1,0,1,0,0,1,1,1,0 on the shift cycles. Required:
  - tail_ones=6 at done, held afterwards.
  - A new start clears tail_ones to 0.
- pReset asserted mid-SHIFT. Required:
  - All outputs go to 0 immediately (asynchronous).
  - After release, state is IDLE and start is needed to resume.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Host-side configuration-chain loader: serialises stream words LSB first onto
// ccff_head with a per-bit shift enable and counts the ones returned on ccff_tail.
module ccff_bitstream_loader #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  tail_ones
);

    localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [WB_W-1:0] LAST_WB = WB_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_WORD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_bit_cnt;
    logic [WB_W-1:0]     r_word_bit;
    logic [WORD_W-1:0]   r_sreg;
    logic                r_head;
    logic                r_en;
    logic [LEN_W-1:0]    r_tail_ones;

    state_t              w_state_next;
    logic [LEN_W-1:0]    w_len_next;
    logic [LEN_W-1:0]    w_bit_cnt_next;
    logic [WB_W-1:0]     w_word_bit_next;
    logic [WORD_W-1:0]   w_sreg_next;
    logic                w_head_next;
    logic                w_en_next;
    logic [LEN_W-1:0]    w_tail_next;
    logic                w_ready;
    logic [LEN_W-1:0]    w_cnt_inc;
    logic                w_last_bit;
    logic                w_word_end;

    // In SHIFT, r_head holds the bit the chain captures at the end of this cycle
    // and r_bit_cnt counts bits already captured, so the final bit is known here.
    assign w_cnt_inc  = r_bit_cnt + LEN_W'(1);
    assign w_last_bit = (w_cnt_inc == r_len);
    assign w_word_end = (r_word_bit == LAST_WB);

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_bit_cnt   <= '0;
            r_word_bit  <= '0;
            r_sreg      <= '0;
            r_head      <= 1'b0;
            r_en        <= 1'b0;
            r_tail_ones <= '0;
        end else begin
            r_state     <= w_state_next;
            r_len       <= w_len_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_word_bit  <= w_word_bit_next;
            r_sreg      <= w_sreg_next;
            r_head      <= w_head_next;
            r_en        <= w_en_next;
            r_tail_ones <= w_tail_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_len_next      = r_len;
        w_bit_cnt_next  = r_bit_cnt;
        w_word_bit_next = r_word_bit;
        w_sreg_next     = r_sreg;
        w_head_next     = r_head;
        w_en_next       = 1'b0;
        w_tail_next     = r_tail_ones;
        w_ready         = 1'b0;

        // Abort freezes the tail count even if the chain shifts on this edge.
        if (r_en && ccff_tail && !abort && (r_tail_ones != {LEN_W{1'b1}})) begin
            w_tail_next = r_tail_ones + LEN_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        w_len_next     = cfg_len;
                        w_bit_cnt_next = '0;
                        w_tail_next    = '0;
                        w_state_next   = ST_WAIT_WORD;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_WAIT_WORD: begin
                w_ready = !abort;
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (s_valid) begin
                    w_head_next     = s_data[0];
                    w_sreg_next     = s_data >> 1;
                    w_word_bit_next = '0;
                    w_en_next       = 1'b1;
                    w_state_next    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_bit_cnt_next = w_cnt_inc;
                    if (w_last_bit) begin
                        w_state_next = ST_DONE;
                    end else if (w_word_end) begin
                        // Next word may be handed over now so the chain sees no bubble.
                        w_ready = 1'b1;
                        if (s_valid) begin
                            w_head_next     = s_data[0];
                            w_sreg_next     = s_data >> 1;
                            w_word_bit_next = '0;
                            w_en_next       = 1'b1;
                        end else begin
                            w_state_next = ST_WAIT_WORD;
                        end
                    end else begin
                        w_head_next     = r_sreg[0];
                        w_sreg_next     = r_sreg >> 1;
                        w_word_bit_next = r_word_bit + WB_W'(1);
                        w_en_next       = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign s_ready   = w_ready;
    assign ccff_head = r_head;
    assign ccff_en   = r_en;
    assign busy      = (r_state == ST_WAIT_WORD) || (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign tail_ones = r_tail_ones;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: a queue-based model of the expected
// bit stream and tail count is checked every cycle, plus literal expectations.
module tb_ccff_bitstream_loader;

    logic        prog_clk;
    logic        pReset;
    logic        start;
    logic [15:0] cfg_len;
    logic        abort;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ccff_head;
    logic        ccff_en;
    logic        ccff_tail;
    logic        busy;
    logic        done;
    logic [15:0] tail_ones;

    ccff_bitstream_loader #(.WORD_W(8), .LEN_W(16)) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .start     (start),
        .cfg_len   (cfg_len),
        .abort     (abort),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .ccff_head (ccff_head),
        .ccff_en   (ccff_en),
        .ccff_tail (ccff_tail),
        .busy      (busy),
        .done      (done),
        .tail_ones (tail_ones)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  src_q[$];
    int          hold_q[$];
    logic        exp_q[$];
    logic        tail_q[$];
    int          bits_left;
    int          model_tail = 0;
    int          cyc = 0;
    int          hs_cnt = 0, en_cnt = 0, done_cnt = 0, ready_cnt = 0;
    int          hs0, en0, done0, rdy0;
    int          first_en, last_en, done_cyc;
    logic [31:0] seen;
    int          seen_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the queue model.
    initial begin
        forever begin
            @(negedge prog_clk);
            cyc++;
            if (pReset) begin
                check("tail_ones_model", 32'(tail_ones), 32'(model_tail));
                if (ccff_en) begin
                    en_cnt++;
                    if (first_en < 0) first_en = cyc;
                    last_en = cyc;
                    if (seen_idx < 32) seen[seen_idx] = ccff_head;
                    seen_idx++;
                    check("en_busy", 32'(busy), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_bit: got ccff_en=1 at cycle %0d, expected no more bits", cyc);
                    end else begin
                        check("head_bit", 32'(ccff_head), 32'(exp_q.pop_front()));
                    end
                    if (ccff_tail && !abort && model_tail < 65535) model_tail++;
                end
                if (s_ready) ready_cnt++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_en", 32'(ccff_en), 32'd0);
                    check("done_ready", 32'(s_ready), 32'd0);
                end
                if (start && cfg_len != 16'd0) model_tail = 0;
            end else begin
                model_tail = 0;
            end
        end
    end

    // Word source: hold_q[0] is how many requested cycles to starve before offering a word.
    initial begin
        logic hs, starve;
        s_valid = 1'b0;
        s_data  = 8'h00;
        forever begin
            @(negedge prog_clk);
            hs     = s_valid && s_ready;
            starve = !s_valid && s_ready && (hold_q.size() > 0);
            @(posedge prog_clk);
            #1;
            if (hs && src_q.size() > 0) begin
                void'(src_q.pop_front());
                void'(hold_q.pop_front());
                hs_cnt++;
            end else if (starve && hold_q.size() > 0 && hold_q[0] > 0) begin
                hold_q[0] = hold_q[0] - 1;
            end
            if (src_q.size() > 0 && hold_q[0] == 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'h00;
            end
        end
    end

    // Chain tail emulation: one scripted bit per shift cycle.
    initial begin
        ccff_tail = 1'b0;
        forever begin
            @(posedge prog_clk);
            #1;
            if (ccff_en && tail_q.size() > 0) ccff_tail = tail_q.pop_front();
            else ccff_tail = 1'b0;
        end
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic add_word(input logic [7:0] w, input int hold);
        src_q.push_back(w);
        hold_q.push_back(hold);
        for (int i = 0; i < 8; i++) begin
            if (bits_left > 0) begin
                exp_q.push_back(w[i]);
                bits_left--;
            end
        end
    endtask

    task automatic flush_all();
        src_q.delete();
        hold_q.delete();
        exp_q.delete();
        tail_q.delete();
    endtask

    task automatic begin_load(input logic [15:0] len);
        seen     = '0;
        seen_idx = 0;
        first_en = -1;
        last_en  = -1;
        hs0      = hs_cnt;
        en0      = en_cnt;
        done0    = done_cnt;
        rdy0     = ready_cnt;
        tick();
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n = 0;
        while (done_cnt == done0 && n < max_cyc) begin
            @(negedge prog_clk);
            #1;
            n++;
        end
        if (done_cnt == done0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected one", name, max_cyc);
        end
    endtask

    task automatic wait_en(input int n, input int max_cyc);
        int k = 0;
        while (en_cnt - en0 < n && k < max_cyc) begin
            @(negedge prog_clk);
            #1;
            k++;
        end
        if (en_cnt - en0 < n) begin
            checks++;
            errors++;
            $display("FAIL wait_en_timeout: got %0d shift cycles, expected %0d", en_cnt - en0, n);
        end
    endtask

    task automatic finish_load(input string name, input int len, input int words);
        wait_done(name, 80);
        check({name, "_handshakes"}, 32'(hs_cnt - hs0), 32'(words));
        check({name, "_en_cycles"}, 32'(en_cnt - en0), 32'(len));
        check({name, "_bits_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_done_after_last"}, 32'(done_cyc), 32'(last_en + 1));
        $display("load %s len=%0d handshakes=%0d shifts=%0d tail_ones=%0d", name, len,
                 hs_cnt - hs0, en_cnt - en0, tail_ones);
        tick();
        tick();
        check({name, "_single_done"}, 32'(done_cnt - done0), 32'd1);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        pReset  = 1'b1;
        start   = 1'b0;
        cfg_len = 16'd0;
        abort   = 1'b0;
        first_en = -1;
        last_en  = -1;
        done_cyc = -1;
        seen     = '0;
        seen_idx = 0;
        #2 pReset = 1'b0;
        #1;
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_head", 32'(ccff_head), 32'd0);
        check("rst_en", 32'(ccff_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tail_ones", 32'(tail_ones), 32'd0);
        repeat (3) @(posedge prog_clk);
        #1 pReset = 1'b1;
        tick();

        // 12 bits from 0xA5, 0x03 with the source always ready
        bits_left = 12;
        add_word(8'hA5, 0);
        add_word(8'h03, 0);
        begin_load(16'd12);
        finish_load("t1", 12, 2);
        check("t1_seq", seen, 32'h0000_03A5);
        check("t1_no_bubble", 32'(last_en - first_en + 1), 32'd12);

        // Same load, second word starved for 3 requested cycles
        bits_left = 12;
        add_word(8'hA5, 0);
        add_word(8'h03, 3);
        begin_load(16'd12);
        finish_load("t2", 12, 2);
        check("t2_seq", seen, 32'h0000_03A5);
        check("t2_gap_ge3", 32'((last_en - first_en + 1 - 12) >= 3), 32'd1);

        // Zero-length load
        hs0 = hs_cnt; en0 = en_cnt; done0 = done_cnt; rdy0 = ready_cnt;
        tick();
        start = 1'b1;
        cfg_len = 16'd0;
        @(negedge prog_clk);
        #1;
        check("t3_done_not_yet", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        @(negedge prog_clk);
        #1;
        check("t3_done", 32'(done), 32'd1);
        tick();
        tick();
        check("t3_done_count", 32'(done_cnt - done0), 32'd1);
        check("t3_no_ready", 32'(ready_cnt - rdy0), 32'd0);
        check("t3_no_en", 32'(en_cnt - en0), 32'd0);
        check("t3_no_hs", 32'(hs_cnt - hs0), 32'd0);
        $display("load t3 len=0 done_pulses=%0d", done_cnt - done0);

        // 20-bit load aborted after the 5th shift
        bits_left = 20;
        add_word(8'h5A, 0);
        add_word(8'hC3, 0);
        add_word(8'h0F, 0);
        begin_load(16'd20);
        wait_en(5, 40);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_en", 32'(ccff_en), 32'd0);
        check("t4_abort_busy", 32'(busy), 32'd0);
        check("t4_abort_ready", 32'(s_ready), 32'd0);
        #2 flush_all();
        repeat (4) tick();
        check("t4_no_done", 32'(done_cnt - done0), 32'd0);
        check("t4_shifts", 32'(en_cnt - en0), 32'd6);
        check("t4_handshakes", 32'(hs_cnt - hs0), 32'd1);
        check("t4_seq", seen & 32'h3F, 32'h0000_001A);
        $display("load t4 len=20 aborted after %0d shifts", en_cnt - en0);
        bits_left = 8;
        add_word(8'h3C, 0);
        begin_load(16'd8);
        finish_load("t4b", 8, 1);
        check("t4b_seq", seen, 32'h0000_003C);

        // Tail monitor: 1,1,0,1,0,0,1,1,1,0 -> six ones
        bits_left = 10;
        add_word(8'hFF, 0);
        add_word(8'h01, 0);
        tail_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        begin_load(16'd10);
        wait_done("t5", 80);
        check("t5_tail_at_done", 32'(tail_ones), 32'd6);
        check("t5_seq", seen, 32'h0000_01FF);
        repeat (3) tick();
        check("t5_tail_held", 32'(tail_ones), 32'd6);
        $display("load t5 len=10 tail_ones=%0d", tail_ones);
        bits_left = 8;
        add_word(8'h00, 0);
        begin_load(16'd8);
        check("t5_tail_cleared", 32'(tail_ones), 32'd0);
        finish_load("t5b", 8, 1);

        // Asynchronous reset in the middle of a shift
        bits_left = 16;
        add_word(8'hFF, 0);
        add_word(8'hFF, 0);
        begin_load(16'd16);
        wait_en(3, 40);
        #2 pReset = 1'b0;
        #1;
        check("t6_rst_ready", 32'(s_ready), 32'd0);
        check("t6_rst_head", 32'(ccff_head), 32'd0);
        check("t6_rst_en", 32'(ccff_en), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_tail", 32'(tail_ones), 32'd0);
        flush_all();
        repeat (2) @(posedge prog_clk);
        #1 pReset = 1'b1;
        en0 = en_cnt;
        repeat (3) tick();
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_en", 32'(ccff_en), 32'd0);
        check("t6_idle_ready", 32'(s_ready), 32'd0);
        check("t6_idle_no_shift", 32'(en_cnt - en0), 32'd0);
        $display("reset t6 mid-shift, loader idle after release");
        bits_left = 8;
        add_word(8'h81, 0);
        begin_load(16'd8);
        finish_load("t6b", 8, 1);
        check("t6b_seq", seen, 32'h0000_0081);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
